// File: rtl/smart_throttle_if.sv
// Alert/throttle signal bundle between board pins and the SmaRT throttle controller.
// The master side drives the alert inputs; the slave side is the controller.
interface smart_throttle_if #(
    parameter int NUM_ALERTS = 2
) ();
    logic [NUM_ALERTS-1:0] iAlert_n;
    logic [NUM_ALERTS-1:0] iAlertEn;
    logic                  iPwrOk;
    logic                  iStatusClr;
    logic                  oThrottle;
    logic [NUM_ALERTS-1:0] oAlertStatus;
    logic                  oHoldActive;

    modport master (
        output iAlert_n, iAlertEn, iPwrOk, iStatusClr,
        input  oThrottle, oAlertStatus, oHoldActive
    );

    modport slave (
        input  iAlert_n, iAlertEn, iPwrOk, iStatusClr,
        output oThrottle, oAlertStatus, oHoldActive
    );
endinterface

// File: rtl/smart_throttle_ctrl.sv
// SmaRT system-throttle controller: synchronised, glitch-filtered alert aggregation
// with minimum hold time, power-good gating and sticky per-channel status.
module smart_throttle_ctrl #(
    parameter int NUM_ALERTS    = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2000,
    parameter int CNT_W         = 12
) (
    input logic               iClk,
    input logic               iRst_n,
    smart_throttle_if.slave   bus
);

    localparam int FILT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_THROTTLE = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;

    logic [NUM_ALERTS-1:0] sync_p0;
    logic [NUM_ALERTS-1:0] sync_p1;
    logic [NUM_ALERTS-1:0] filt_p2;
    logic [FILT_W-1:0]     filt_cnt [NUM_ALERTS];
    logic [NUM_ALERTS-1:0] req;
    logic                  any_req;
    logic [1:0]            state;
    logic [CNT_W-1:0]      hold_cnt;
    logic [NUM_ALERTS-1:0] alert_status;

    // Stage p0/p1: two-flop synchroniser on the asynchronous alert pins
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= bus.iAlert_n;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: symmetric run-length filter, independent of enable and power-good
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            filt_p2 <= '1;
            for (int i = 0; i < NUM_ALERTS; i++) filt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ALERTS; i++) begin
                if (sync_p1[i] != filt_p2[i]) begin
                    if (filt_cnt[i] == FILT_LAST) begin
                        filt_p2[i]  <= sync_p1[i];
                        filt_cnt[i] <= '0;
                    end else begin
                        filt_cnt[i] <= filt_cnt[i] + FILT_W'(1);
                    end
                end else begin
                    filt_cnt[i] <= '0;
                end
            end
        end
    end

    assign req     = bus.iAlertEn & ~filt_p2;
    assign any_req = |req;

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.iPwrOk && any_req) state <= ST_THROTTLE;
                end
                ST_THROTTLE: begin
                    if (!bus.iPwrOk) begin
                        state <= ST_IDLE;
                    end else if (!any_req) begin
                        if (HOLD_CYCLES > 0) begin
                            state    <= ST_HOLD;
                            hold_cnt <= HOLD_LOAD;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!bus.iPwrOk) begin
                        state <= ST_IDLE;
                    end else if (any_req) begin
                        state <= ST_THROTTLE;
                    end else if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Set dominates clear so an alert active during the clear pulse is not lost
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            alert_status <= '0;
        end else begin
            alert_status <= (alert_status & ~{NUM_ALERTS{bus.iStatusClr}})
                          | (req & {NUM_ALERTS{bus.iPwrOk}});
        end
    end

    assign bus.oThrottle    = (state != ST_IDLE);
    assign bus.oHoldActive  = (state == ST_HOLD);
    assign bus.oAlertStatus = alert_status;

endmodule

// File: tb/tb_smart_throttle_ctrl.sv
// Scoreboard bench: two controllers (hold enabled / hold disabled) share stimulus and
// are checked every cycle against a run-length / mode reference model.
module tb_smart_throttle_ctrl;

    localparam int N = 2;
    localparam int F = 4;
    localparam int H = 2000;

    typedef struct packed {
        logic         thr;
        logic [N-1:0] st;
        logic         hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    smart_throttle_if #(.NUM_ALERTS(N)) if0 ();
    smart_throttle_if #(.NUM_ALERTS(N)) if1 ();

    smart_throttle_ctrl #(.NUM_ALERTS(N), .FILTER_CYCLES(F), .HOLD_CYCLES(H), .CNT_W(12)) dut0 (
        .iClk(clk), .iRst_n(rst_n), .bus(if0));
    smart_throttle_ctrl #(.NUM_ALERTS(N), .FILTER_CYCLES(F), .HOLD_CYCLES(0), .CNT_W(12)) dut1 (
        .iClk(clk), .iRst_n(rst_n), .bus(if1));

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic [N-1:0] cur_an  = '1;
    logic [N-1:0] cur_en  = '0;
    logic         cur_pwr = 1'b0;

    // Reference model state, one copy per DUT configuration
    logic [N-1:0] m_s1 [2];
    logic [N-1:0] m_s2 [2];
    logic [N-1:0] m_filt [2];
    logic [N-1:0] m_stat [2];
    bit           run_val [2][N];
    int           run_len [2][N];
    int           m_mode [2];   // 0 idle, 1 throttling, 2 holding
    int           m_left [2];

    task automatic model_step(input int d, input logic rstn, input logic [N-1:0] an,
                              input logic [N-1:0] en, input logic pwr, input logic clr);
        logic [N-1:0] req;
        int hcfg;
        exp_t e;
        hcfg = (d == 0) ? H : 0;
        if (!rstn) begin
            m_s1[d] = '1; m_s2[d] = '1; m_filt[d] = '1; m_stat[d] = '0;
            m_mode[d] = 0; m_left[d] = 0;
            for (int c = 0; c < N; c++) begin run_val[d][c] = 1'b1; run_len[d][c] = 0; end
        end else begin
            req = en & ~m_filt[d];
            if (!pwr) m_mode[d] = 0;
            else if (req != '0) m_mode[d] = 1;
            else if (m_mode[d] == 1) begin
                if (hcfg > 0) begin m_mode[d] = 2; m_left[d] = hcfg - 1; end
                else m_mode[d] = 0;
            end else if (m_mode[d] == 2) begin
                if (m_left[d] == 0) m_mode[d] = 0;
                else m_left[d] = m_left[d] - 1;
            end
            m_stat[d] = (clr ? '0 : m_stat[d]) | (pwr ? req : '0);
            // Filtered level follows the synchronised value once it has been stable F samples
            for (int c = 0; c < N; c++) begin
                if (m_s2[d][c] == run_val[d][c]) run_len[d][c]++;
                else begin run_val[d][c] = m_s2[d][c]; run_len[d][c] = 1; end
                if (run_len[d][c] >= F && run_val[d][c] != m_filt[d][c]) m_filt[d][c] = run_val[d][c];
            end
            m_s2[d] = m_s1[d];
            m_s1[d] = an;
        end
        e.thr  = (m_mode[d] != 0);
        e.hold = (m_mode[d] == 2);
        e.st   = m_stat[d];
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic tick(input logic rstn, input logic clr);
        @(negedge clk);
        rst_n = rstn;
        if0.iAlert_n = cur_an; if0.iAlertEn = cur_en; if0.iPwrOk = cur_pwr; if0.iStatusClr = clr;
        if1.iAlert_n = cur_an; if1.iAlertEn = cur_en; if1.iPwrOk = cur_pwr; if1.iStatusClr = clr;
        model_step(0, rstn, cur_an, cur_en, cur_pwr, clr);
        model_step(1, rstn, cur_an, cur_en, cur_pwr, clr);
    endtask

    task automatic step(input int n);
        repeat (n) tick(1'b1, 1'b0);
    endtask

    task automatic check(input int d, input exp_t e, input logic thr, input logic [N-1:0] st,
                         input logic hold);
        n_cmp++;
        if (thr !== e.thr) begin
            n_err++;
            $display("FAIL dut%0d throttle cyc=%0d got=%b want=%b", d, cyc, thr, e.thr);
        end
        n_cmp++;
        if (st !== e.st) begin
            n_err++;
            $display("FAIL dut%0d status cyc=%0d got=%b want=%b", d, cyc, st, e.st);
        end
        n_cmp++;
        if (hold !== e.hold) begin
            n_err++;
            $display("FAIL dut%0d hold_active cyc=%0d got=%b want=%b", d, cyc, hold, e.hold);
        end
    endtask

    // Monitor: every clock edge consumes one expected result per DUT
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check(0, e, if0.oThrottle, if0.oAlertStatus, if0.oHoldActive);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check(1, e, if1.oThrottle, if1.oAlertStatus, if1.oHoldActive);
            end
        end
    end

    initial begin
        int rl [N];
        int pwr_low;
        rst_n = 1'b0;
        if0.iAlert_n = '1; if0.iAlertEn = '0; if0.iPwrOk = 1'b0; if0.iStatusClr = 1'b0;
        if1.iAlert_n = '1; if1.iAlertEn = '0; if1.iPwrOk = 1'b0; if1.iStatusClr = 1'b0;
        repeat (3) tick(1'b0, 1'b0);

        // Single alert assert, release, full hold
        cur_pwr = 1'b1; cur_en = '1;
        step(2);
        cur_an[0] = 1'b0; step(10);
        cur_an[0] = 1'b1; step(H + 20);

        // Short glitch is rejected, filter-length pulse is accepted
        tick(1'b1, 1'b1);
        cur_an[1] = 1'b0; step(3);
        cur_an[1] = 1'b1; step(10);
        cur_an[1] = 1'b0; step(4);
        cur_an[1] = 1'b1; step(H + 10);

        // Re-assert during hold, then full hold again
        cur_an[0] = 1'b0; step(10);
        cur_an[0] = 1'b1; step(1500);
        cur_an[0] = 1'b0; step(10);
        cur_an[0] = 1'b1; step(H + 20);

        // Power-good drop and recovery with alert still active
        cur_an[0] = 1'b0; step(10);
        cur_pwr = 1'b0; step(3);
        cur_pwr = 1'b1; step(3);
        cur_an[0] = 1'b1; step(H + 10);

        // Disabled channel, re-enable, clear while request active
        tick(1'b1, 1'b1);
        cur_en = 2'b10;
        cur_an[0] = 1'b0; step(10);
        cur_en = 2'b11; step(3);
        tick(1'b1, 1'b1);
        step(2);
        cur_an[0] = 1'b1; step(H + 10);

        // Reset in the middle of hold
        cur_an[0] = 1'b0; step(10);
        cur_an[0] = 1'b1; step(100);
        tick(1'b0, 1'b0);
        step(10);

        // Randomised phase
        for (int c = 0; c < N; c++) rl[c] = 0;
        pwr_low = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < N; c++) begin
                if (rl[c] == 0) begin
                    cur_an[c] = 1'($urandom_range(0, 1));
                    rl[c] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 40))
                                                        : int'($urandom_range(1, 6));
                end else rl[c]--;
            end
            if ($urandom_range(0, 199) == 0) cur_en = N'($urandom_range(0, (1 << N) - 1));
            if (pwr_low > 0) pwr_low--;
            else if ($urandom_range(0, 299) == 0) pwr_low = int'($urandom_range(1, 5));
            cur_pwr = (pwr_low == 0);
            tick($urandom_range(0, 999) != 0, $urandom_range(0, 39) == 0);
        end

        cur_an = '1;
        step(2);
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want=0", q0.size() + q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
